// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-read-port register file.
//   regfile_state_e : clear/run state of the power-up clear sequencer
//   DEF_*           : default geometry used by the top-level parameters
//   addr_width()    : address width for a given register count
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regfile_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;

  // Guard the degenerate single-entry case so the address is never 0 bits wide.
  function automatic int addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
//   clk_i, reset_i   : clock, synchronous active-high reset (clears all bits)
//   run_i            : high once the register file is ready; gates every update and lookup
//   wr_en_i/wr_addr_i: writeback, clears the busy bit of wr_addr_i
//   busy_set_i/busy_addr_i : issue, sets the busy bit of busy_addr_i
//   rd_addr_i        : packed read-port addresses
//   rd_busy_o        : per-port pending flag for the addressed register
module regfile_scoreboard #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     run_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic                     busy_set_i,
  input  logic [ADDR_W-1:0]        busy_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clear is applied before set, so a producer issued in the same cycle as an
  // older producer's writeback to the same register keeps the bit pending.
  always_comb begin
    busy_d = busy_q;
    if (run_i) begin
      if (wr_en_i)    busy_d[wr_addr_i]   = 1'b0;
      if (busy_set_i) busy_d[busy_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  // A writeback landing this cycle resolves the hazard, matching the data bypass.
  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy_o[i] = run_i
                   & busy_q[rd_addr_i[i*ADDR_W +: ADDR_W]]
                   & ~(wr_en_i && (wr_addr_i == rd_addr_i[i*ADDR_W +: ADDR_W]));
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write-first bypass,
// optional hardwired zero register, power-up clear sequencer and a
// per-register pending-write scoreboard.
//   clk, reset        : clock, synchronous active-high reset (restarts the clear)
//   rd_addr / rd_data : packed read ports, port i at [i*W +: W], combinational
//   rd_busy           : per-port pending-write flag of the addressed register
//   wr_en/wr_addr/wr_data : single write port
//   busy_set/busy_addr: marks a register as having a pending write
//   ready             : high once every entry has been cleared
//   dbg_state         : current sequencer state
//
// ready is a level, not a handshake: there is no valid/ready pairing on any
// port. While ready=0 all writes and busy_sets are dropped and every read
// port returns zero data and zero busy; once ready=1 it stays high until reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = addr_width(DEPTH),
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  output logic                     ready,
  output regfile_state_e           dbg_state
);

  regfile_state_e    state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_we;
  logic              wr_accept;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign ready     = (state_q == RUN);
  assign dbg_state = state_q;

  // Sequencer: one entry cleared per cycle, last entry hands over to RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Writes to register 0 are dropped when it is hardwired to zero.
  assign wr_accept = ready && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Storage is not reset directly; the clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we)         mem_q[clr_cnt_q] <= '0;
      else if (wr_accept) mem_q[wr_addr]   <= wr_data;
    end
  end

  // Read muxes: zero register first, then same-cycle write bypass, then storage.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ready) begin
        if ((ZERO_REG != 0) && (rd_addr[i*ADDR_W +: ADDR_W] == '0))
          rd_data[i*DATA_W +: DATA_W] = '0;
        else if (wr_en && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W]))
          rd_data[i*DATA_W +: DATA_W] = wr_data;
        else
          rd_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i       (clk),
    .reset_i     (reset),
    .run_i       (ready),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .busy_set_i  (busy_set),
    .busy_addr_i (busy_addr),
    .rd_addr_i   (rd_addr),
    .rd_busy_o   (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (DEPTH=32, DATA_W=32, NUM_RD=4, ZERO_REG=1).
// The driver pushes hand-computed expectations into a queue each cycle; a
// monitor drains the queue shortly after every falling edge and compares.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*W-1:0]    rd_data;
  logic [NR-1:0]      rd_busy;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [W-1:0]       wr_data;
  logic               busy_set;
  logic [AW-1:0]      busy_addr;
  logic               ready;
  regfile_state_e     dbg_state;

  regfile_mp #(
    .DATA_W   (W),
    .DEPTH    (32),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .ready     (ready),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           kind_q[$];   // kind*4 + port; kind 0=data, 1=busy, 2=ready
  string        name_q[$];
  int           tests_run    = 0;
  int           tests_failed = 0;

  task automatic exp_data(input int p, input logic [W-1:0] v, input string n);
    exp_q.push_back(v); kind_q.push_back(p); name_q.push_back(n);
  endtask

  task automatic exp_busy(input int p, input logic v, input string n);
    exp_q.push_back({31'b0, v}); kind_q.push_back(4 + p); name_q.push_back(n);
  endtask

  task automatic exp_ready(input logic v, input string n);
    exp_q.push_back({31'b0, v}); kind_q.push_back(8); name_q.push_back(n);
  endtask

  // Monitor: samples 2 time units after the falling edge, when the driver has
  // already settled this cycle's inputs and queued its expectations.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        logic [W-1:0] e, a;
        int           k;
        string        n;
        e = exp_q.pop_front();
        k = kind_q.pop_front();
        n = name_q.pop_front();
        case (k / 4)
          0:       a = rd_data[(k % 4)*W +: W];
          1:       a = {31'b0, rd_busy[k % 4]};
          default: a = {31'b0, ready};
        endcase
        tests_run++;
        if (a !== e) begin
          tests_failed++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic bs, input logic [AW-1:0] ba,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    busy_set  = bs;
    busy_addr = ba;
    rd_addr   = {a3, a2, a1, a0};
  endtask

  task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    drive(1'b0, '0, '0, 1'b0, '0, a0, a1, a2, a3);
  endtask

  // Watchdog: the run is a few hundred cycles; anything far beyond is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle(0, 0, 0, 0);
    cyc();
    // Reset applied at the first rising edge; drop it now.
    reset = 1'b0;
    exp_ready(1'b0, "ready_after_reset");
    exp_data(0, 32'h0, "data_gated_reset");

    // Initial clear: 32 edges until ready. Writes/sets issued meanwhile are dropped.
    for (int c = 1; c <= 32; c++) begin
      cyc();
      if (c == 5)       drive(1'b0, '0, '0, 1'b1, 5'd4, 0, 0, 0, 0);
      else if (c == 20) drive(1'b1, 5'd6, 32'h0000_0066, 1'b0, '0, 6, 0, 0, 0);
      else              idle(0, 1, 2, 3);
      if (c < 32) begin
        exp_ready(1'b0, "ready_low_clear");
        if (c == 20) exp_data(0, 32'h0, "no_bypass_in_clear");
        if (c == 5)  exp_busy(0, 1'b0, "busy_gated_clear");
      end else begin
        exp_ready(1'b1, "ready_at_32");
        for (int p = 0; p < NR; p++) exp_data(p, 32'h0, "scan_zero");
      end
    end

    // Scan every register: all zero, none busy (r4 set and r6 write were dropped).
    for (int b = 1; b < 8; b++) begin
      cyc();
      idle(AW'(4*b), AW'(4*b+1), AW'(4*b+2), AW'(4*b+3));
      for (int p = 0; p < NR; p++) begin
        exp_data(p, 32'h0, "scan_zero");
        exp_busy(p, 1'b0, "scan_not_busy");
      end
    end

    // Write-first bypass and persistence.
    cyc(); drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, 5, 6, 0, 0);
    exp_data(0, 32'hDEAD_BEEF, "bypass_r5");
    exp_data(1, 32'h0, "other_port_r6");
    cyc(); idle(5, 0, 0, 0);
    exp_data(0, 32'hDEAD_BEEF, "stored_r5");

    // Hardwired zero register: write and busy_set both ignored.
    cyc(); drive(1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 0, 0, 0, 0);
    for (int p = 0; p < NR; p++) exp_data(p, 32'h0, "r0_no_bypass");
    cyc(); idle(0, 0, 0, 0);
    for (int p = 0; p < NR; p++) begin
      exp_data(p, 32'h0, "r0_reads_zero");
      exp_busy(p, 1'b0, "r0_never_busy");
    end

    // Scoreboard on r7.
    cyc(); drive(1'b0, '0, '0, 1'b1, 5'd7, 0, 7, 0, 0);
    exp_busy(1, 1'b0, "r7_set_takes_edge");
    cyc(); idle(7, 7, 7, 7);
    for (int p = 0; p < NR; p++) exp_busy(p, 1'b1, "r7_busy_all_ports");
    cyc(); drive(1'b1, 5'd7, 32'h0000_0077, 1'b0, '0, 0, 7, 0, 0);
    exp_busy(1, 1'b0, "r7_writeback_resolves");
    exp_data(1, 32'h0000_0077, "r7_bypass");
    cyc(); idle(0, 7, 0, 0);
    exp_busy(1, 1'b0, "r7_cleared");
    exp_data(1, 32'h0000_0077, "r7_stored");
    cyc(); drive(1'b1, 5'd7, 32'h0000_0078, 1'b1, 5'd7, 0, 7, 0, 0);
    exp_busy(1, 1'b0, "r7_wr_set_same_cycle");
    exp_data(1, 32'h0000_0078, "r7_bypass2");
    cyc(); idle(0, 7, 0, 0);
    exp_busy(1, 1'b1, "r7_set_wins");
    exp_data(1, 32'h0000_0078, "r7_stored2");

    // All four ports on one register.
    cyc(); drive(1'b1, 5'd9, 32'h0BAD_F00D, 1'b0, '0, 0, 0, 0, 0);
    cyc(); drive(1'b0, '0, '0, 1'b1, 5'd9, 0, 0, 0, 0);
    cyc(); idle(9, 9, 9, 9);
    for (int p = 0; p < NR; p++) begin
      exp_data(p, 32'h0BAD_F00D, "r9_shared");
      exp_busy(p, 1'b1, "r9_busy_shared");
    end

    // Reset in RUN restarts the clear; writes during the clear are ignored.
    cyc(); drive(1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, '0, 0, 0, 0, 0);
    cyc(); idle(3, 0, 0, 0);
    exp_data(0, 32'hA5A5_A5A5, "r3_before_reset");
    cyc(); reset = 1'b1; idle(0, 0, 0, 0);
    cyc(); reset = 1'b0; idle(3, 0, 0, 0);
    exp_ready(1'b0, "ready_low_after_rerst");
    exp_data(0, 32'h0, "gated_after_rerst");
    exp_busy(0, 1'b0, "busy_gated_rerst");
    for (int c = 1; c <= 32; c++) begin
      cyc();
      if (c == 2)       drive(1'b1, 5'd3, 32'h0000_0001, 1'b0, '0, 3, 0, 0, 0);
      else if (c == 10) drive(1'b1, 5'd3, 32'h0000_0001, 1'b1, 5'd3, 3, 0, 0, 0);
      else if (c == 32) idle(3, 7, 9, 5);
      else              idle(3, 0, 0, 0);
      if (c < 32) begin
        exp_ready(1'b0, "ready_low_reclear");
      end else begin
        exp_ready(1'b1, "ready_at_32_reclear");
        for (int p = 0; p < NR; p++) begin
          exp_data(p, 32'h0, "cleared_after_rerst");
          exp_busy(p, 1'b0, "busy_cleared_rerst");
        end
      end
    end

    cyc(); idle(0, 0, 0, 0);
    #3;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the MIPS datapath; successor to the single-pair register file.
- Configurable data width, depth and read-port count, with optional hardwired zero register and write-to-read bypass.
- Clears its contents sequentially after reset and signals `ready` when done.
- Holds a per-register pending-write scoreboard, so decode can detect RAW hazards without a separate block.

Parameters:
- DATA_W, 32, width of each register in bits
- DEPTH, 32, number of registers; power of two, >= 2
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, if 1 register 0 always reads 0, ignores writes, and is never busy

Ports:
- clk, input, 1, rising-edge clock for all state
- reset, input, 1, synchronous active-high reset
- rd_addr, input, NUM_RD*ADDR_W, packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data, output, NUM_RD*DATA_W, packed combinational read data
- rd_busy, output, NUM_RD, per-port flag: addressed register has a pending write
- wr_en, input, 1, write strobe
- wr_addr, input, ADDR_W, write address
- wr_data, input, DATA_W, write data
- busy_set, input, 1, an issued instruction will write busy_addr; marks it pending
- busy_addr, input, ADDR_W, scoreboard set address
- ready, output, 1, high once the clear sequence completes

Behaviour:
- One clock, clk; reset is synchronous and active-high. All writes happen on the rising edge; there is no negedge logic.
- FSM has two states, CLEAR and RUN. Reset takes the state to CLEAR with clr_cnt=0, ready=0 and all busy bits 0.
- CLEAR state:
  - Each non-reset cycle writes 0 to entry clr_cnt, then increments clr_cnt.
  - When clr_cnt==DEPTH-1, that entry is cleared and the state goes to RUN.
  - ready rises exactly DEPTH clocks after reset deasserts.
- Reset asserted mid-CLEAR or in RUN restarts the clear from entry 0.
- While ready=0:
  - wr_en and busy_set are ignored.
  - rd_data is all zeros.
  - rd_busy is all zeros.
- Read port i, when ready=1:
  - rd_data[i] = wr_data if wr_en && wr_addr==rd_addr[i] (write-first bypass, same cycle); otherwise mem[rd_addr[i]].
  - ZERO_REG=1 and rd_addr[i]==0 gives 0, and the bypass is suppressed.
- Write: with wr_en=1 in RUN, mem[wr_addr] <= wr_data at the edge. When ZERO_REG=1, a write to address 0 is dropped.
- Scoreboard, on the edge in RUN:
  - wr_en clears busy[wr_addr].
  - busy_set sets busy[busy_addr].
  - If both target the same address, the set wins (the new producer supersedes).
  - busy[0] stays 0 when ZERO_REG=1.
- rd_busy[i] = busy[rd_addr[i]] & ~(wr_en && wr_addr==rd_addr[i]). The same-cycle writeback counts as resolved, consistent with the bypass.
- Several read ports may share an address; each returns identical data and busy.
- No out-of-range addresses are possible because DEPTH is a power of two.

Decomposition:
- Shared package regfile_pkg holds the state enum {CLEAR, RUN} and helper constants (ADDR_W calc).
- One natural sub-module: regfile_scoreboard, holding the DEPTH busy bits, set/clear priority and per-port lookup.
- Storage, bypass muxes and the clear FSM stay in the top module.

Test Plan:
- Reset 1 cycle, then idle, with DEPTH=32 -> ready=0 for 32 clocks and 1 on the 33rd; reading all 32 addresses gives 0x00000000.
- After ready, write 0xDEADBEEF to r5 while rd_addr[0]=5 in the same cycle -> rd_data[0]=0xDEADBEEF combinationally; the next cycle with no write still gives 0xDEADBEEF.
- Write 0x12345678 to r0 with ZERO_REG=1 -> reads of r0 on all ports give 0; busy_set on r0 -> rd_busy stays 0.
- busy_set r7, then next cycle rd_addr[1]=7 -> rd_busy[1]=1. A cycle with wr_en to r7 -> rd_busy[1]=0 that cycle. Same-cycle wr_en r7 plus busy_set r7 -> busy stays 1 afterwards.
- Write r3=0xA5A5A5A5, assert reset for 1 cycle, then wr_en to r3 with 0x1 at clear cycle 2 -> write ignored, ready after 32 more clocks, r3 reads 0.
- NUM_RD=4, all ports address r9 holding 0x0BADF00D -> all four rd_data equal 0x0BADF00D and rd_busy matches on all ports.
